// File: rtl/jk_mod_counter_pkg.sv
// Shared definitions for the JK-based modulo counter: excitation codes and
// the helper that maps a (present, next) bit pair onto a {J,K} pair.
package jk_mod_counter_pkg;

  localparam int unsigned JK_W = 2;

  // {J,K} excitation codes presented to a JK storage cell
  localparam logic [JK_W-1:0] JK_HOLD   = 2'b00;
  localparam logic [JK_W-1:0] JK_RESET  = 2'b01;
  localparam logic [JK_W-1:0] JK_SET    = 2'b10;
  localparam logic [JK_W-1:0] JK_TOGGLE = 2'b11;

  // J = ~q & next, K = q & ~next; never produces JK_TOGGLE
  function automatic logic [JK_W-1:0] jk_excite(input logic q_bit, input logic next_bit);
    return {~q_bit & next_bit, q_bit & ~next_bit};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flip-flop storage cell.
// Ports: clk, rst (async, active-high, clears to 0), j_i/k_i excitation, q_o state.
module jk_cell
  import jk_mod_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // JK characteristic equation
  always_comb begin
    q_d = q_q;
    case ({j_i, k_i})
      JK_HOLD:   q_d = q_q;
      JK_RESET:  q_d = 1'b0;
      JK_SET:    q_d = 1'b1;
      JK_TOGGLE: q_d = ~q_q;
      default:   q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives in one JK cell per bit.
// Ports:
//   clk, rst       clock and async active-high reset
//   en, up         count enable and direction (1 = up)
//   load, load_val synchronous parallel load (priority over en)
//   q              current count
//   tc             combinational terminal count, for cascading the next digit
//   wrap           registered pulse, cycle after the count wrapped
//   load_err       registered pulse, cycle after a load_val >= MODULUS
module jk_mod_counter
  import jk_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("jk_mod_counter: MODULUS out of range for WIDTH");
  end

  // Compare is one bit wider so MODULUS = 2**WIDTH is representable
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_cells;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  // Next count: load > en > hold
  always_comb begin
    cnt_d      = q_cells;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        cnt_d = load_val;
      end else begin
        cnt_d      = '0;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (q_cells == CNT_MAX) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = q_cells + WIDTH'(1);
        end
      end else begin
        if (q_cells == '0) begin
          cnt_d  = CNT_MAX;
          wrap_d = 1'b1;
        end else begin
          cnt_d = q_cells - WIDTH'(1);
        end
      end
    end
  end

  // Per-bit excitation and storage
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j_c[i], k_c[i]} = jk_excite(q_cells[i], cnt_d[i]);

    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j_i (j_c[i]),
      .k_i (k_c[i]),
      .q_o (q_cells[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_cells;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
  assign tc       = en & ((up & (q_cells == CNT_MAX)) | (~up & (q_cells == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
module tb_jk_mod_counter;

  typedef struct {
    int unsigned q;
    int unsigned wrap;
    int unsigned err;
  } exp_t;

  localparam int unsigned M = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tc, wrap, load_err;

  logic       en8, up8, load8;
  logic [2:0] lv8;
  logic [2:0] q8;
  logic       tc8, wrap8, err8;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned mq      = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8), .load_val(lv8),
    .q(q8), .tc(tc8), .wrap(wrap8), .load_err(err8)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus on the MODULUS=10 counter; entered just after a rising edge
  task automatic step(input logic l, input int unsigned v, input logic e, input logic u);
    exp_t x;
    int unsigned tc_exp;
    load = l; load_val = 4'(v); en = e; up = u;
    #1;
    tc_exp = (e && ((u && mq == M-1) || (!u && mq == 0))) ? 1 : 0;
    check("tc", int'(tc), tc_exp);
    check("no_toggle", int'(|(dut.j_c & dut.k_c)), 0);
    if (!l && !e) check("jk_hold", int'({dut.j_c, dut.k_c}), 0);
    x.wrap = 0; x.err = 0;
    if (l) begin
      if (v < M) mq = v;
      else begin mq = 0; x.err = 1; end
    end else if (e) begin
      if (u) begin x.wrap = (mq == M-1) ? 1 : 0; mq = (mq + 1) % M; end
      else   begin x.wrap = (mq == 0) ? 1 : 0;   mq = (mq + M - 1) % M; end
    end
    x.q = mq;
    sb.push_back(x);
    @(posedge clk); #1;
    if (sb.size() == 0) check("sb_empty", 1, 0);
    else begin
      x = sb.pop_front();
      check("q", int'(q), x.q);
      check("wrap", int'(wrap), x.wrap);
      check("load_err", int'(load_err), x.err);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    en8 = 1'b0; up8 = 1'b1; load8 = 1'b0; lv8 = '0;
    @(posedge clk); #1;
    check("rst_q", int'(q), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_err", int'(load_err), 0);
    rst = 1'b0;

    // Count to 7, then async reset between edges
    for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b1, 1'b1);
    check("pre_rst_q", int'(q), 7);
    #3 rst = 1'b1;
    #1;
    check("async_q", int'(q), 0);
    check("async_wrap", int'(wrap), 0);
    check("async_err", int'(load_err), 0);
    @(posedge clk); #1;
    check("rst_hold_q", int'(q), 0);
    rst = 1'b0; mq = 0;
    step(1'b0, 0, 1'b1, 1'b1);

    // Up wrap from 0 over 12 edges
    step(1'b1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 0, 1'b1, 1'b1);

    // Down wrap from 2
    step(1'b1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);

    // Load priority and out-of-range load, including back-to-back errors
    step(1'b1, 5, 1'b1, 1'b1);
    step(1'b1, 12, 1'b1, 1'b0);
    step(1'b1, 15, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b1, 9, 1'b0, 1'b1);
    step(1'b1, 10, 1'b1, 1'b1);

    // Hold at 6
    step(1'b1, 6, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 1'b0, 1'b0);

    // Random mix, load kept rare
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 7) == 0), $urandom_range(0, 15),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));

    // Full-range config: WIDTH=3, MODULUS=8
    load8 = 1'b1; lv8 = 3'd7;
    @(posedge clk); #1;
    check("m8_load", int'(q8), 7);
    check("m8_load_err", int'(err8), 0);
    load8 = 1'b0; en8 = 1'b1; up8 = 1'b1;
    #1 check("m8_tc_up", int'(tc8), 1);
    @(posedge clk); #1;
    check("m8_up_q", int'(q8), 0);
    check("m8_up_wrap", int'(wrap8), 1);
    up8 = 1'b0;
    #1 check("m8_tc_dn", int'(tc8), 1);
    @(posedge clk); #1;
    check("m8_dn_q", int'(q8), 7);
    check("m8_dn_wrap", int'(wrap8), 1);
    en8 = 1'b0;
    @(posedge clk); #1;
    check("m8_hold_q", int'(q8), 7);
    check("m8_hold_wrap", int'(wrap8), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
